ace_snoop_monitor: RTL

Synthesizable, parametrised passive monitor for one ACE snoop interface (AC, CR and CD channels). It sits beside the master's snoop ports in the HDL partition, drives no bus signals, and runs on emulator or simulator without VIP support. It tracks outstanding snoops in order and counts snoop-data beats per cache line. Protocol violations are reported as sticky error flags, and statistics counters are exported for the HVL scoreboard.

---
 rtl/ace_snoop_monitor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ace_snoop_monitor.sv
// Passive ACE snoop-channel monitor: in-order snoop tracking, per-line CD beat counting, sticky errors, stats.
// Latency: every output is registered; a handshake shows up on the cycle after the ACLK edge that samples it.
// Backpressure: none applied. The monitor drives no bus signal and only observes the VALID/READY pairs.
// Optional watchdog on the oldest outstanding snoop: define ACE_SNOOP_MON_TIMEOUT_EN to build it.
module ace_snoop_monitor #(
  parameter int ADDR_WIDTH       = 64,
  parameter int SNOOP_DATA_WIDTH = 128,
  parameter int CACHE_LINE_SIZE  = 6,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic                               ACVALID,
  input  logic                               ACREADY,
  input  logic [ADDR_WIDTH-1:0]              ACADDR,
  input  logic [3:0]                         ACSNOOP,
  input  logic                               CRVALID,
  input  logic                               CRREADY,
  input  logic [4:0]                         CRRESP,
  input  logic                               CDVALID,
  input  logic                               CDREADY,
  input  logic                               CDLAST,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [31:0]                        snoop_count,
  output logic [31:0]                        resp_count,
  output logic [31:0]                        data_line_count,
  output logic [6:0]                         err,
  input  logic                               err_clear
);

  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BPL = ((2 ** CACHE_LINE_SIZE) * 8) / SNOOP_DATA_WIDTH;
  localparam int BW  = $clog2(BPL) + 1;
  localparam int PW  = OW + 1;
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BPL_V   = BW'(BPL);

  // Only the DataTransfer bit of CRRESP affects the tracking.
  logic unused_crresp;
  assign unused_crresp = ^CRRESP[4:1];

  // The snoop payload is never read back, so the in-order tracker reduces to its occupancy.
  logic [OW-1:0]         out_q, out_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [31:0]           snp_cnt_q, snp_cnt_d;
  logic [31:0]           rsp_cnt_q, rsp_cnt_d;
  logic [31:0]           line_cnt_q, line_cnt_d;
  logic [6:0]            err_q, err_d;
  logic                  prev_ok_q;
  logic                  pv_vld_q, pv_rdy_q;
  logic [ADDR_WIDTH-1:0] pv_addr_q;
  logic [3:0]            pv_snp_q;

  logic ac_hs, cr_hs, cd_hs;
  logic tr_full, tr_empty, push, pop, cr_data;
  logic data_ok, cd_ok, line_end, short_line, line_done, long_beat;
  logic ac_unstable, wd_err;
  logic [BW-1:0] beat_n;
  logic [6:0]    err_new;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign ac_hs = ACVALID & ACREADY;
  assign cr_hs = CRVALID & CRREADY;
  assign cd_hs = CDVALID & CDREADY;

  // Event decode and next-state computation for tracker, line counting, errors and counters.
  always_comb begin
    tr_full    = (out_q == OUT_MAX);
    tr_empty   = (out_q == '0);
    pop        = cr_hs & ~tr_empty;
    // A pop frees a slot in the same cycle, so a push onto a full tracker is accepted alongside it.
    push       = ac_hs & (~tr_full | pop);
    cr_data    = pop & CRRESP[0];
    data_ok    = (pend_q != '0) | cr_data;
    cd_ok      = cd_hs & data_ok;
    // Saturate so an overlong line cannot wrap the beat counter back into the early-last window.
    beat_n     = (beat_q == '1) ? beat_q : beat_q + 1'b1;
    line_end   = cd_ok & CDLAST;
    short_line = line_end & (beat_n < BPL_V);
    line_done  = line_end & ~short_line;
    long_beat  = cd_ok & ~CDLAST & (beat_n == BPL_V);

    ac_unstable = prev_ok_q & pv_vld_q & ~pv_rdy_q &
                  (~ACVALID | (ACADDR != pv_addr_q) | (ACSNOOP != pv_snp_q));

    out_d = out_q;
    if (push && !pop)      out_d = out_q + 1'b1;
    else if (pop && !push) out_d = out_q - 1'b1;

    // A line that closes in the same cycle its CR arrives leaves pending_lines unchanged.
    pend_d = pend_q;
    if (cr_data && !line_end && (pend_q != '1)) pend_d = pend_q + 1'b1;
    else if (line_end && !cr_data)              pend_d = pend_q - 1'b1;

    beat_d = beat_q;
    if (line_end)   beat_d = '0;
    else if (cd_ok) beat_d = beat_n;

    snp_cnt_d  = sat_inc(snp_cnt_q, ac_hs);
    rsp_cnt_d  = sat_inc(rsp_cnt_q, pop);
    line_cnt_d = sat_inc(line_cnt_q, line_done);

    err_new = {wd_err, ac_unstable, cd_hs & ~data_ok, long_beat, short_line,
               ac_hs & tr_full & ~pop, cr_hs & tr_empty};
    // A fresh error wins over a simultaneous clear.
    err_d   = (err_clear ? 7'h00 : err_q) | err_new;
  end

  // State registers with synchronous reset; reset discards any half-finished line without flagging it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_q      <= '0;
      pend_q     <= '0;
      beat_q     <= '0;
      snp_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      line_cnt_q <= '0;
      err_q      <= '0;
      prev_ok_q  <= 1'b0;
      pv_vld_q   <= 1'b0;
      pv_rdy_q   <= 1'b0;
      pv_addr_q  <= '0;
      pv_snp_q   <= '0;
    end else begin
      out_q      <= out_d;
      pend_q     <= pend_d;
      beat_q     <= beat_d;
      snp_cnt_q  <= snp_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
      prev_ok_q  <= 1'b1;
      pv_vld_q   <= ACVALID;
      pv_rdy_q   <= ACREADY;
      pv_addr_q  <= ACADDR;
      pv_snp_q   <= ACSNOOP;
    end
  end

`ifdef ACE_SNOOP_MON_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  logic [WW-1:0] wd_q, wd_d;

  // Watchdog next state: restart on any response, count while snoops are pending, hold at the limit.
  always_comb begin
    wd_d = wd_q;
    if (cr_hs)                                wd_d = '0;
    else if ((out_q != '0) && (wd_q != WD_MAX)) wd_d = wd_q + 1'b1;
  end

  assign wd_err = ~cr_hs & (wd_q == WD_MAX);

  // Watchdog register.
  always_ff @(posedge ACLK) begin
    if (ARESET) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_err = 1'b0;
`endif

  assign outstanding     = out_q;
  assign snoop_count     = snp_cnt_q;
  assign resp_count      = rsp_cnt_q;
  assign data_line_count = line_cnt_q;
  assign err             = err_q;

endmodule
